// File: rtl/fl_frame_dropper.sv
// fl_frame_dropper: admits whole FrameLink frames only when the downstream FIFO can absorb them.
// Define FL_FRAME_DROPPER_STATS_EN to build the pass/drop/truncate counters.
module fl_frame_dropper #(
    parameter int DATA_WIDTH      = 64,
    parameter int MAX_FRAME_WORDS = 256,
    parameter int FREE_WIDTH      = 10,
    parameter int CNT_WIDTH       = 32,
    localparam int REM_WIDTH      = (DATA_WIDTH > 8) ? $clog2(DATA_WIDTH / 8) : 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic [REM_WIDTH-1:0]  rx_rem,
    input  logic                  rx_sof_n,
    input  logic                  rx_eof_n,
    input  logic                  rx_sop_n,
    input  logic                  rx_eop_n,
    input  logic                  rx_src_rdy_n,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic [REM_WIDTH-1:0]  tx_rem,
    output logic                  tx_sof_n,
    output logic                  tx_eof_n,
    output logic                  tx_sop_n,
    output logic                  tx_eop_n,
    output logic                  tx_src_rdy_n,
    input  logic                  tx_dst_rdy_n,
    input  logic [FREE_WIDTH-1:0] free_words,
    input  logic                  cnt_clr,
    output logic [CNT_WIDTH-1:0]  pass_cnt,
    output logic [CNT_WIDTH-1:0]  drop_cnt,
    output logic [CNT_WIDTH-1:0]  trunc_cnt
);
    localparam int WCNT_WIDTH = $clog2(MAX_FRAME_WORDS + 1);
    localparam logic [1:0] IDLE = 2'd0, PASS = 2'd1, DROP = 2'd2;
    logic [1:0] state, state_nx;
    logic [WCNT_WIDTH-1:0] wcnt, wcnt_nx;
    logic rx_vld, loadable, sof, eof, admit;
    logic load, force_eof, overflow, inc_pass, inc_drop, inc_trunc;
    always_comb begin
        rx_vld    = !rx_src_rdy_n;
        loadable  = tx_src_rdy_n || !tx_dst_rdy_n;
        sof       = !rx_sof_n;
        eof       = !rx_eof_n;
        admit     = enable && (32'(free_words) >= MAX_FRAME_WORDS) && loadable;
        state_nx  = state;
        wcnt_nx   = wcnt;
        load      = 1'b0;
        force_eof = 1'b0;
        overflow  = 1'b0;
        inc_pass  = 1'b0;
        inc_drop  = 1'b0;
        inc_trunc = 1'b0;
        case (state)
            IDLE: if (rx_vld && sof) begin
                load     = admit;
                inc_pass = admit;
                inc_drop = !admit;
                wcnt_nx  = admit ? WCNT_WIDTH'(1) : wcnt;
                state_nx = eof ? IDLE : (admit ? PASS : DROP);
            end
            PASS: if (rx_vld) begin
                if (loadable) begin
                    load      = 1'b1;
                    wcnt_nx   = wcnt + 1'b1;
                    force_eof = !eof && (wcnt_nx == WCNT_WIDTH'(MAX_FRAME_WORDS));
                    inc_trunc = force_eof;
                    state_nx  = eof ? IDLE : (force_eof ? DROP : PASS);
                end else begin
                    // word is lost: close the held word as the frame's last
                    overflow  = 1'b1;
                    inc_trunc = 1'b1;
                    state_nx  = eof ? IDLE : DROP;
                end
            end
            DROP: state_nx = (rx_vld && eof) ? IDLE : DROP;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            wcnt         <= '0;
            tx_data      <= '0;
            tx_rem       <= '0;
            tx_sof_n     <= 1'b1;
            tx_eof_n     <= 1'b1;
            tx_sop_n     <= 1'b1;
            tx_eop_n     <= 1'b1;
            tx_src_rdy_n <= 1'b1;
        end else begin
            state <= state_nx;
            wcnt  <= wcnt_nx;
            if (load) begin
                tx_data      <= rx_data;
                tx_rem       <= rx_rem;
                tx_sof_n     <= rx_sof_n || (state != IDLE);
                tx_sop_n     <= rx_sop_n;
                tx_eof_n     <= rx_eof_n && !force_eof;
                tx_eop_n     <= rx_eop_n && !force_eof;
                tx_src_rdy_n <= 1'b0;
            end else begin
                if (!tx_src_rdy_n && !tx_dst_rdy_n)
                    tx_src_rdy_n <= 1'b1;
                if (overflow) begin
                    tx_eof_n <= 1'b0;
                    tx_eop_n <= 1'b0;
                end
            end
        end
    end
`ifdef FL_FRAME_DROPPER_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pass_cnt  <= '0;
            drop_cnt  <= '0;
            trunc_cnt <= '0;
        end else if (cnt_clr) begin
            pass_cnt  <= '0;
            drop_cnt  <= '0;
            trunc_cnt <= '0;
        end else begin
            pass_cnt  <= pass_cnt + CNT_WIDTH'(inc_pass);
            drop_cnt  <= drop_cnt + CNT_WIDTH'(inc_drop);
            trunc_cnt <= trunc_cnt + CNT_WIDTH'(inc_trunc);
        end
    end
`else
    logic unused_stats;
    assign unused_stats = ^{cnt_clr, inc_pass, inc_drop, inc_trunc};
    assign pass_cnt  = '0;
    assign drop_cnt  = '0;
    assign trunc_cnt = '0;
`endif
endmodule

// File: tb/tb_fl_frame_dropper.sv
// tb_fl_frame_dropper: directed tests of admission, drop, truncation, overflow and counters.
module tb_fl_frame_dropper;
    localparam int DW = 64, MAXW = 8, FW = 10, CW = 32;
`ifdef FL_FRAME_DROPPER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif
    logic clk, reset_n, enable, cnt_clr;
    logic [DW-1:0] rx_data, tx_data;
    logic [2:0] rx_rem, tx_rem;
    logic rx_sof_n, rx_eof_n, rx_sop_n, rx_eop_n, rx_src_rdy_n;
    logic tx_sof_n, tx_eof_n, tx_sop_n, tx_eop_n, tx_src_rdy_n, tx_dst_rdy_n;
    logic [FW-1:0] free_words;
    logic [CW-1:0] pass_cnt, drop_cnt, trunc_cnt;
    int errors = 0, checks = 0;
    int e_pass = 0, e_drop = 0, e_trunc = 0;
    logic [65:0] q[$];

    fl_frame_dropper #(.DATA_WIDTH(DW), .MAX_FRAME_WORDS(MAXW), .FREE_WIDTH(FW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .rx_data(rx_data), .rx_rem(rx_rem), .rx_sof_n(rx_sof_n), .rx_eof_n(rx_eof_n),
        .rx_sop_n(rx_sop_n), .rx_eop_n(rx_eop_n), .rx_src_rdy_n(rx_src_rdy_n),
        .tx_data(tx_data), .tx_rem(tx_rem), .tx_sof_n(tx_sof_n), .tx_eof_n(tx_eof_n),
        .tx_sop_n(tx_sop_n), .tx_eop_n(tx_eop_n), .tx_src_rdy_n(tx_src_rdy_n),
        .tx_dst_rdy_n(tx_dst_rdy_n), .free_words(free_words), .cnt_clr(cnt_clr),
        .pass_cnt(pass_cnt), .drop_cnt(drop_cnt), .trunc_cnt(trunc_cnt)
    );

    always #5 clk = ~clk;

    // capture every word that will transfer at the coming rising edge
    always @(negedge clk)
        if (reset_n && !tx_src_rdy_n && !tx_dst_rdy_n)
            q.push_back({tx_sof_n, tx_eof_n, tx_data});

    function automatic logic [CW-1:0] ev(input int n);
        return STATS ? CW'(n) : '0;
    endfunction

    task automatic cyc(input logic v, input logic sof, input logic eof, input logic [63:0] d);
        rx_src_rdy_n = !v;
        rx_sof_n = !sof;
        rx_sop_n = !sof;
        rx_eof_n = !eof;
        rx_eop_n = !eof;
        rx_data = d;
        rx_rem = d[2:0];
        @(posedge clk);
        #1;
    endtask

    task automatic frame(input int n, input logic [63:0] base);
        for (int i = 0; i < n; i++) cyc(1'b1, i == 0, i == n - 1, base + 64'(i));
    endtask

    task automatic settle;
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 64'd0);
    endtask

    task automatic test_reset;
        checks++; if (tx_src_rdy_n !== 1'b1) begin errors++; $display("FAIL reset_src_rdy: got %b want 1", tx_src_rdy_n); end
        checks++; if ({tx_sof_n, tx_eof_n, tx_sop_n, tx_eop_n} !== 4'hf) begin errors++; $display("FAIL reset_framing: got %b want 1111", {tx_sof_n, tx_eof_n, tx_sop_n, tx_eop_n}); end
        checks++; if (tx_data !== 64'd0 || tx_rem !== 3'd0) begin errors++; $display("FAIL reset_data: got %h/%h want 0/0", tx_data, tx_rem); end
        checks++; if ({pass_cnt, drop_cnt, trunc_cnt} !== '0) begin errors++; $display("FAIL reset_cnt: got %0d %0d %0d want 0 0 0", pass_cnt, drop_cnt, trunc_cnt); end
    endtask

    task automatic test_pass;
        logic [65:0] w;
        q.delete();
        cyc(1'b1, 1'b1, 1'b0, 64'h100);
        checks++; if (tx_src_rdy_n !== 1'b0 || tx_data !== 64'h100 || tx_sof_n !== 1'b0) begin errors++; $display("FAIL pass_latency: got rdy=%b d=%h sof=%b want 0 100 0", tx_src_rdy_n, tx_data, tx_sof_n); end
        cyc(1'b1, 1'b0, 1'b0, 64'h101);
        cyc(1'b1, 1'b0, 1'b0, 64'h102);
        cyc(1'b1, 1'b0, 1'b1, 64'h103);
        settle();
        e_pass++;
        checks++; if (q.size() != 4) begin errors++; $display("FAIL pass_len: got %0d want 4", q.size()); end
        for (int i = 0; i < 4 && i < q.size(); i++) begin
            w = {i != 0, i != 3, 64'('h100 + i)};
            checks++; if (q[i] !== w) begin errors++; $display("FAIL pass_word%0d: got %h want %h", i, q[i], w); end
        end
        checks++; if (pass_cnt !== ev(e_pass)) begin errors++; $display("FAIL pass_cnt: got %0d want %0d", pass_cnt, ev(e_pass)); end
    endtask

    task automatic test_drop_free;
        logic [65:0] w;
        q.delete();
        free_words = 10'd5;
        frame(4, 64'h200);
        settle();
        e_drop++;
        checks++; if (q.size() != 0) begin errors++; $display("FAIL dropfree_len: got %0d want 0", q.size()); end
        checks++; if (drop_cnt !== ev(e_drop)) begin errors++; $display("FAIL dropfree_drop_cnt: got %0d want %0d", drop_cnt, ev(e_drop)); end
        free_words = 10'd300;
        frame(3, 64'h300);
        settle();
        e_pass++;
        checks++; if (q.size() != 3) begin errors++; $display("FAIL dropfree_next_len: got %0d want 3", q.size()); end
        for (int i = 0; i < 3 && i < q.size(); i++) begin
            w = {i != 0, i != 2, 64'('h300 + i)};
            checks++; if (q[i] !== w) begin errors++; $display("FAIL dropfree_word%0d: got %h want %h", i, q[i], w); end
        end
        checks++; if (pass_cnt !== ev(e_pass)) begin errors++; $display("FAIL dropfree_pass_cnt: got %0d want %0d", pass_cnt, ev(e_pass)); end
    endtask

    task automatic test_trunc;
        logic [65:0] w;
        q.delete();
        frame(12, 64'h400);
        settle();
        e_pass++;
        e_trunc++;
        checks++; if (q.size() != 8) begin errors++; $display("FAIL trunc_len: got %0d want 8", q.size()); end
        for (int i = 0; i < 8 && i < q.size(); i++) begin
            w = {i != 0, i != 7, 64'('h400 + i)};
            checks++; if (q[i] !== w) begin errors++; $display("FAIL trunc_word%0d: got %h want %h", i, q[i], w); end
        end
        checks++; if (trunc_cnt !== ev(e_trunc)) begin errors++; $display("FAIL trunc_cnt: got %0d want %0d", trunc_cnt, ev(e_trunc)); end
        q.delete();
        frame(2, 64'h500);
        settle();
        e_pass++;
        checks++; if (q.size() != 2) begin errors++; $display("FAIL trunc_next_len: got %0d want 2", q.size()); end
        checks++; if (pass_cnt !== ev(e_pass)) begin errors++; $display("FAIL trunc_pass_cnt: got %0d want %0d", pass_cnt, ev(e_pass)); end
    endtask

    task automatic test_overflow;
        logic [65:0] w;
        q.delete();
        tx_dst_rdy_n = 1'b0;
        cyc(1'b1, 1'b1, 1'b0, 64'h600);
        cyc(1'b1, 1'b0, 1'b0, 64'h601);
        cyc(1'b1, 1'b0, 1'b0, 64'h602);
        tx_dst_rdy_n = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, 64'h603);
        cyc(1'b1, 1'b0, 1'b0, 64'h604);
        checks++; if (tx_src_rdy_n !== 1'b0 || tx_data !== 64'h602 || tx_eof_n !== 1'b0 || tx_eop_n !== 1'b0) begin errors++; $display("FAIL ovf_held: got rdy=%b d=%h eof=%b eop=%b want 0 602 0 0", tx_src_rdy_n, tx_data, tx_eof_n, tx_eop_n); end
        tx_dst_rdy_n = 1'b0;
        cyc(1'b1, 1'b0, 1'b1, 64'h605);
        settle();
        e_pass++;
        e_trunc++;
        checks++; if (q.size() != 3) begin errors++; $display("FAIL ovf_len: got %0d want 3", q.size()); end
        for (int i = 0; i < 3 && i < q.size(); i++) begin
            w = {i != 0, i != 2, 64'('h600 + i)};
            checks++; if (q[i] !== w) begin errors++; $display("FAIL ovf_word%0d: got %h want %h", i, q[i], w); end
        end
        checks++; if (trunc_cnt !== ev(e_trunc)) begin errors++; $display("FAIL ovf_trunc_cnt: got %0d want %0d", trunc_cnt, ev(e_trunc)); end
    endtask

    task automatic test_back_to_back;
        logic [65:0] w;
        q.delete();
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b1, 64'('h700 + i));
        cyc(1'b1, 1'b0, 1'b0, 64'h7ff);
        settle();
        e_pass += 5;
        checks++; if (q.size() != 5) begin errors++; $display("FAIL b2b_len: got %0d want 5", q.size()); end
        for (int i = 0; i < 5 && i < q.size(); i++) begin
            w = {1'b0, 1'b0, 64'('h700 + i)};
            checks++; if (q[i] !== w) begin errors++; $display("FAIL b2b_word%0d: got %h want %h", i, q[i], w); end
        end
        checks++; if (pass_cnt !== ev(e_pass)) begin errors++; $display("FAIL b2b_pass_cnt: got %0d want %0d", pass_cnt, ev(e_pass)); end
    endtask

    task automatic test_enable;
        q.delete();
        enable = 1'b0;
        for (int f = 0; f < 3; f++) frame(2, 64'('h800 + 16 * f));
        enable = 1'b1;
        settle();
        e_drop += 3;
        checks++; if (q.size() != 0) begin errors++; $display("FAIL en_len: got %0d want 0", q.size()); end
        checks++; if (drop_cnt !== ev(e_drop)) begin errors++; $display("FAIL en_drop_cnt: got %0d want %0d", drop_cnt, ev(e_drop)); end
        cyc(1'b1, 1'b1, 1'b0, 64'h880);
        enable = 1'b0;
        cyc(1'b1, 1'b0, 1'b0, 64'h881);
        cyc(1'b1, 1'b0, 1'b1, 64'h882);
        enable = 1'b1;
        settle();
        e_pass++;
        checks++; if (q.size() != 3) begin errors++; $display("FAIL en_midframe_len: got %0d want 3", q.size()); end
    endtask

    task automatic test_clr;
        q.delete();
        cnt_clr = 1'b1;
        cyc(1'b1, 1'b1, 1'b1, 64'h900);
        cnt_clr = 1'b0;
        settle();
        e_pass = 0;
        e_drop = 0;
        e_trunc = 0;
        checks++; if ({pass_cnt, drop_cnt, trunc_cnt} !== '0) begin errors++; $display("FAIL clr_cnt: got %0d %0d %0d want 0 0 0", pass_cnt, drop_cnt, trunc_cnt); end
        checks++; if (q.size() != 1) begin errors++; $display("FAIL clr_len: got %0d want 1", q.size()); end
        frame(1, 64'h901);
        settle();
        e_pass++;
        checks++; if (pass_cnt !== ev(e_pass)) begin errors++; $display("FAIL clr_pass_cnt: got %0d want %0d", pass_cnt, ev(e_pass)); end
    endtask

    task automatic test_reset_mid;
        cyc(1'b1, 1'b1, 1'b0, 64'ha00);
        cyc(1'b1, 1'b0, 1'b0, 64'ha01);
        reset_n = 1'b0;
        #1;
        checks++; if (tx_src_rdy_n !== 1'b1 || tx_data !== 64'd0 || tx_eof_n !== 1'b1) begin errors++; $display("FAIL rstmid_out: got rdy=%b d=%h eof=%b want 1 0 1", tx_src_rdy_n, tx_data, tx_eof_n); end
        checks++; if (pass_cnt !== '0) begin errors++; $display("FAIL rstmid_cnt: got %0d want 0", pass_cnt); end
        e_pass = 0;
        cyc(1'b0, 1'b0, 1'b0, 64'd0);
        reset_n = 1'b1;
        q.delete();
        cyc(1'b1, 1'b0, 1'b1, 64'ha02);
        frame(2, 64'hb00);
        settle();
        e_pass++;
        checks++; if (q.size() != 2) begin errors++; $display("FAIL rstmid_len: got %0d want 2", q.size()); end
        checks++; if (q.size() > 0 && q[0] !== {2'b01, 64'hb00}) begin errors++; $display("FAIL rstmid_word0: got %h want %h", q[0], {2'b01, 64'hb00}); end
        checks++; if (pass_cnt !== ev(e_pass)) begin errors++; $display("FAIL rstmid_pass_cnt: got %0d want %0d", pass_cnt, ev(e_pass)); end
    endtask

    initial begin
        clk = 1'b0;
        reset_n = 1'b0;
        enable = 1'b1;
        cnt_clr = 1'b0;
        free_words = 10'd300;
        tx_dst_rdy_n = 1'b0;
        rx_data = '0;
        rx_rem = '0;
        {rx_sof_n, rx_eof_n, rx_sop_n, rx_eop_n, rx_src_rdy_n} = 5'h1f;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        reset_n = 1'b1;
        settle();
        test_pass();
        test_drop_free();
        test_trunc();
        test_overflow();
        test_back_to_back();
        test_enable();
        test_clr();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
